// File: rtl/tl_ul_sram_responder.sv
`default_nettype none
// ============================================================================
// Module : tl_ul_sram_responder
// Brief  : TL-UL single-beat manager backed by a byte-maskable word SRAM.
// Rev    : 1.0  initial release
// ============================================================================
module tl_ul_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          SOURCE_W    = 4,
  parameter int          RESP_DELAY  = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [3:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data
);

  localparam int         c_idx_w      = $clog2(DEPTH_WORDS);
  localparam logic [2:0] c_put_full   = 3'd0;
  localparam logic [2:0] c_put_part   = 3'd1;
  localparam logic [2:0] c_get        = 3'd4;
  localparam logic [2:0] c_ack        = 3'd0;
  localparam logic [2:0] c_ack_data   = 3'd1;
  localparam logic [7:0] c_delay_m1   = (RESP_DELAY > 0) ? 8'(RESP_DELAY - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_live;
  logic [7:0]            r_count;
  logic                  r_d_valid;
  logic [2:0]            r_d_opcode;
  logic [3:0]            r_d_size;
  logic [SOURCE_W-1:0]   r_d_source;
  logic                  r_d_denied;
  logic                  r_d_corrupt;
  logic [31:0]           r_d_data;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic                  w_fire;
  logic [31:0]           w_word;
  logic [c_idx_w-1:0]    w_index;
  logic                  w_in_range;
  logic                  w_aligned;
  logic [3:0]            w_full_mask;
  logic                  w_is_get;
  logic                  w_is_put;
  logic                  w_denied;

  // a_ready stays low until the first clock after reset release
  assign a_ready = r_live && (r_state == S_IDLE);
  assign w_fire  = a_valid && a_ready;

  always_comb begin
    w_word      = (a_address - BASE_ADDR) >> 2;
    w_index     = w_word[c_idx_w-1:0];
    w_in_range  = (a_address >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
    w_is_get    = (a_opcode == c_get);
    w_is_put    = (a_opcode == c_put_full) || (a_opcode == c_put_part);
    w_aligned   = 1'b1;
    w_full_mask = 4'hF;
    case (a_size)
      4'd0: begin
        w_aligned   = 1'b1;
        w_full_mask = 4'b0001 << a_address[1:0];
      end
      4'd1: begin
        w_aligned   = ~a_address[0];
        w_full_mask = 4'b0011 << {a_address[1], 1'b0};
      end
      default: begin
        w_aligned   = (a_address[1:0] == 2'b00);
        w_full_mask = 4'hF;
      end
    endcase
    w_denied = !(w_is_get || w_is_put)
            || (a_param != 3'd0)
            || (a_size > 4'd2)
            || !w_aligned
            || !w_in_range
            || ((a_opcode == c_put_full) && (a_mask != w_full_mask))
            || (w_is_get && (a_mask == 4'd0));
  end

  // SRAM contents are deliberately left unreset
  always_ff @(posedge clock) begin
    if (w_fire && w_is_put && !w_denied) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) begin
          r_mem[w_index][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_count     <= 8'd0;
      r_d_valid   <= 1'b0;
      r_d_opcode  <= 3'd0;
      r_d_size    <= 4'd0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= 32'd0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_d_opcode  <= w_is_get ? c_ack_data : c_ack;
            r_d_size    <= a_size;
            r_d_source  <= a_source;
            r_d_denied  <= w_denied;
            r_d_corrupt <= w_is_get && w_denied;
            r_d_data    <= (w_is_get && !w_denied) ? r_mem[w_index] : 32'd0;
            if (RESP_DELAY > 0) begin
              r_state <= S_WAIT;
              r_count <= c_delay_m1;
            end else begin
              r_state   <= S_RESP;
              r_d_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_count == 8'd0) begin
            r_state   <= S_RESP;
            r_d_valid <= 1'b1;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end
        S_RESP: begin
          if (d_ready) begin
            r_state   <= S_IDLE;
            r_d_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_d_valid <= 1'b0;
        end
      endcase
    end
  end

  assign d_valid   = r_d_valid;
  assign d_opcode  = r_d_opcode;
  assign d_param   = 2'b00;
  assign d_size    = r_d_size;
  assign d_source  = r_d_source;
  assign d_denied  = r_d_denied;
  assign d_corrupt = r_d_corrupt;
  assign d_data    = r_d_data;

endmodule
`default_nettype wire
